// File: rtl/add32_seq.sv
// 32-bit add/subtract sequenced over an external 16-bit adder, low half then high half.
// Define ADD32_SAT_EN to clamp signed overflow to the most positive/negative value.
`timescale 1ns/1ps
module add32_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic [15:0] adder_a,
  output logic [15:0] adder_b,
  output logic        adder_cin,
  input  logic [15:0] adder_sum,
  input  logic        adder_cout,
  input  logic        adder_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_cout,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic        carry_q, carry_d;
  logic [31:0] res_q, res_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        vld_q, vld_d;
  logic        rdy_q, rdy_d;

  // Subtraction is A + ~B + 1; the +1 enters as the low-half carry-in.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          sub_d   = in_sub;
          rdy_d   = 1'b0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        res_d[15:0] = adder_sum;
        carry_d     = adder_cout;
        state_d     = S_HI;
      end
      S_HI: begin
        res_d[31:16] = adder_sum;
        cout_d       = adder_cout;
        ovf_d        = adder_ovf;
`ifdef ADD32_SAT_EN
        if (adder_ovf) begin
          res_d = a_q[31] ? 32'h8000_0000
                          : 32'h7FFF_FFFF;
        end
`endif
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    adder_a   = 16'h0000;
    adder_b   = 16'h0000;
    adder_cin = 1'b0;
    unique case (state_q)
      S_LO: begin
        adder_a   = a_q[15:0];
        adder_b   = b_q[15:0];
        adder_cin = sub_q;
      end
      S_HI: begin
        adder_a   = a_q[31:16];
        adder_b   = b_q[31:16];
        adder_cin = carry_q;
      end
      default: begin
        adder_a   = 16'h0000;
        adder_b   = 16'h0000;
        adder_cin = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = vld_q;
  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_add32_seq.sv
// Directed bench for add32_seq with a 16-bit adder model and a result scoreboard.
// Expected results are pushed at issue and popped by a monitor on each output handshake.
`timescale 1ns/1ps
module tb_add32_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [15:0] adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout, adder_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_cout, out_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic prev_vld = 1'b0;
  logic [33:0] exp_q[$];
  int rise_q[$];

  add32_seq dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_cin(adder_cin), .adder_sum(adder_sum),
    .adder_cout(adder_cout), .adder_ovf(adder_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout),
    .out_ovf(out_ovf)
  );

  // External 16-bit adder
  assign {adder_cout, adder_sum} =
    {1'b0, adder_a} + {1'b0, adder_b} + {16'h0, adder_cin};
  assign adder_ovf = (adder_a[15] == adder_b[15]) &&
                     (adder_sum[15] != adder_a[15]);

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (out_valid && !prev_vld) rise_q.push_back(cyc);
    prev_vld = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got %h expected none",
                 out_result);
      end else begin
        chk("result", {30'h0, out_result, out_cout, out_ovf},
            {30'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] er,
                       input logic ec, input logic ev, input bit push);
    int n = 0;
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    while (!in_ready && n < 20) begin step(); n++; end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL issue_timeout: got in_ready 0 expected 1");
    end
    if (push) exp_q.push_back({er, ec, ev});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
    step();
  endtask

  initial begin
    logic [31:0] ovf_res;
    logic [31:0] sub_ovf_res;
`ifdef ADD32_SAT_EN
    ovf_res     = 32'h7FFF_FFFF;
    sub_ovf_res = 32'h8000_0000;
`else
    ovf_res     = 32'h8000_0000;
    sub_ovf_res = 32'h7FFF_FFFF;
`endif
    #2;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_outs", {31'h0, out_result, out_cout, out_ovf}, 64'h0);
    step();
    reset_n = 1'b1;
    chk("rst_ready", {63'h0, in_ready}, 64'h1);
    step();

    // Carry across halves, with latency: DONE three cycles from the accept cycle
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0,
          32'h0001_0000, 1'b0, 1'b0, 1);
    chk("lat_lo", {63'h0, out_valid}, 64'h0);
    step();
    chk("lat_hi", {63'h0, out_valid}, 64'h0);
    step();
    chk("lat_done", {63'h0, out_valid}, 64'h1);
    drain();

    issue(32'h0000_0000, 32'h0000_0001, 1'b1,
          32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    drain();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
          ovf_res, 1'b0, 1'b1, 1);
    drain();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
          32'h0000_0000, 1'b1, 1'b0, 1);
    drain();
    issue(32'h0000_0005, 32'h0000_0003, 1'b1,
          32'h0000_0002, 1'b1, 1'b0, 1);
    drain();
    issue(32'h8000_0000, 32'h0000_0001, 1'b1,
          sub_ovf_res, 1'b1, 1'b1, 1);
    drain();

    // Back-to-back with in_valid held; operands change right after accept
    rise_q.delete();
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_sub = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back({32'h2345_6789, 1'b0, 1'b0});
    step();
    in_a = 32'hA000_0000; in_b = 32'h6000_0000;
    exp_q.push_back({32'h0000_0000, 1'b1, 1'b0});
    begin
      int n = 0;
      step();
      while (!in_ready && n < 20) begin step(); n++; end
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", 64'(rise_q.size()), 64'd2);
    if (rise_q.size() == 2)
      chk("b2b_gap", 64'(rise_q[1] - rise_q[0]), 64'd4);

    // Backpressure: hold DONE for 5 cycles while in_valid pokes at it
    out_ready = 1'b0;
    issue(32'h0000_0010, 32'h0000_0020, 1'b1,
          32'hFFFF_FFF0, 1'b0, 1'b0, 1);
    begin
      int n = 0;
      while (!out_valid && n < 10) begin step(); n++; end
    end
    in_a = 32'h1; in_b = 32'h1; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {30'h0, out_valid, in_ready, out_result},
          {30'h0, 1'b1, 1'b0, 32'hFFFF_FFF0});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", {62'h0, out_valid, in_ready}, 64'h1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    step();

    // Reset in HI aborts the operation
    issue(32'h0001_0005, 32'h0002_0003, 1'b0,
          32'h0, 1'b0, 1'b0, 0);
    step();
    reset_n = 1'b0;
    #1;
    chk("abort_outs", {30'h0, out_valid, out_result, out_cout},
        64'h0);
    chk("abort_ovf_ready", {62'h0, out_ovf, in_ready}, 64'h1);
    chk("abort_adder", {31'h0, adder_a, adder_b, adder_cin}, 64'h0);
    step();
    reset_n = 1'b1;
    chk("abort_rdy", {63'h0, in_ready}, 64'h1);
    repeat (6) step();
    chk("abort_quiet", {63'h0, out_valid}, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
